// File: rtl/rv_md_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_md_pkg;

    localparam int MD_XLEN = 32;
    // Clocks from the accepting edge to the done pulse for an iterated op.
    localparam int MD_LAT  = MD_XLEN + 2;

    // RV funct3 encodings for the M extension.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Divide family is the upper half of the funct3 space.
    function automatic logic md_is_div(input md_op_e o);
        return o[2];
    endfunction

endpackage

// File: rtl/md_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step is registered.
module md_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quot_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quot_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          ge;

    // Partial remainder stays below the divisor, so the kept difference always fits XLEN bits.
    always_comb begin
        shifted  = {rem_in, quot_in[XLEN-1]};
        diff     = shifted - {1'b0, divisor};
        ge       = (shifted >= {1'b0, divisor});
        rem_out  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quot_out = {quot_in[XLEN-2:0], ge};
    end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one step per clock.
// Latency: XLEN+2 clocks from accept to done; div-by-zero/overflow finish in 1 clock when SPECIAL_FAST.
// Backpressure: start is ignored while busy; requester holds it until accepted (also accepted in DONE).
module md_unit #(
    parameter int XLEN         = 32,
    parameter bit SPECIAL_FAST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   data0,
    input  logic [XLEN-1:0]   data1,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [2*XLEN-1:0] mul_res
);
    import rv_md_pkg::*;

    md_state_e state, next_state;

    // Datapath: acc is {product_hi, multiplier} for mul, {remainder, dividend/quotient} for div.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [5:0]        count;
    logic              neg_res;
    logic              neg_rem;
    md_op_e            op_q;

    md_op_e            op_in;
    logic              in_div;
    logic              sa, sb;
    logic              d0_neg, d1_neg;
    logic [XLEN-1:0]   abs0, abs1;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   fast_quot, fast_rem, fast_res;
    logic              accept;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   step_rem, step_quot;
    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN-1:0]   fix_quot, fix_rem;

    assign op_in  = md_op_e'(op);
    assign in_div = md_is_div(op_in);
    assign accept = start && !flush && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN) || (state == FIX);
    assign done   = (state == DONE);

    // Operand signedness and magnitudes at acceptance; signs are reapplied in FIX.
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (op_in)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                sa = 1'b1;
                sb = 1'b1;
            end
            MD_MULHSU: sa = 1'b1;
            default: ;
        endcase
        d0_neg    = sa && data0[XLEN-1];
        d1_neg    = sb && data1[XLEN-1];
        abs0      = d0_neg ? (~data0 + 1'b1) : data0;
        abs1      = d1_neg ? (~data1 + 1'b1) : data1;
        div_zero  = in_div && (data1 == '0);
        div_ovf   = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (data0 == {1'b1, {(XLEN-1){1'b0}}}) && (data1 == '1);
        special   = SPECIAL_FAST && (div_zero || div_ovf);
        fast_quot = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        fast_rem  = div_zero ? data0 : '0;
        fast_res  = op_in[1] ? fast_rem : fast_quot;
    end

    // Shared divide step on the current remainder/quotient halves.
    md_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_in   (acc[2*XLEN-1:XLEN]),
        .quot_in  (acc[XLEN-1:0]),
        .divisor  (opnd),
        .rem_out  (step_rem),
        .quot_out (step_quot)
    );

    // Multiply step and final sign correction.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
        fix_prod = neg_res ? (~acc + 1'b1) : acc;
        fix_quot = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        fix_rem  = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) next_state = special ? DONE : RUN;
                else        next_state = IDLE;
            end
            RUN:     if (count == 6'(XLEN-1)) next_state = FIX;
            FIX:     next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // Datapath and held outputs; flush leaves outputs untouched, reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            opnd    <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            op_q    <= MD_MUL;
            result  <= '0;
            mul_res <= '0;
        end else if (!flush) begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        count   <= '0;
                        neg_res <= (d0_neg ^ d1_neg) && !div_zero;
                        neg_rem <= in_div && d0_neg;
                        if (in_div) begin
                            acc  <= {{XLEN{1'b0}}, abs0};
                            opnd <= abs1;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, abs1};
                            opnd <= abs0;
                        end
                        if (special) begin
                            result  <= fast_res;
                            mul_res <= {fast_rem, fast_quot};
                        end
                    end
                end
                RUN: begin
                    count <= count + 6'd1;
                    if (md_is_div(op_q)) acc <= {step_rem, step_quot};
                    else                 acc <= {mul_sum, acc[XLEN-1:1]};
                end
                FIX: begin
                    if (md_is_div(op_q)) begin
                        mul_res <= {fix_rem, fix_quot};
                        result  <= op_q[1] ? fix_rem : fix_quot;
                    end else begin
                        mul_res <= fix_prod;
                        result  <= (op_q == MD_MUL) ? fix_prod[XLEN-1:0]
                                                    : fix_prod[2*XLEN-1:XLEN];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: functional vectors, latency, flush, reset, back-to-back, busy start.
// Latency: n/a.
// Backpressure: n/a.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, flush, start;
    logic [2:0]  op;
    logic [31:0] data0, data1;
    logic        busy, done;
    logic [31:0] result;
    logic [63:0] mul_res;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic [63:0] mres;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    md_unit #(.XLEN(32), .SPECIAL_FAST(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .start   (start),
        .op      (op),
        .data0   (data0),
        .data1   (data1),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .mul_res (mul_res)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current cycle, then counts clocks to done (lat=-1 on timeout).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] r, output logic [63:0] m);
        op = o; data0 = a; data1 = b; start = 1'b1;
        tick();
        start = 1'b0; op = 3'd3; data0 = 32'hDEADBEEF; data1 = 32'h0BADF00D;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                lat = n + 1;
                break;
            end
            tick();
        end
        r = result;
        m = mul_res;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; start = 1'b0; op = 3'd0; data0 = '0; data1 = '0;
        tick(); tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
        tests++; if (mul_res !== 64'h0) begin fails++; $display("FAIL reset_mul_res got %h want 0", mul_res); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        vec_t v [12];
        int          lat;
        logic [31:0] r;
        logic [63:0] m;
        v[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 64'hFFFFFFFF_FFFFFFEB, 34};
        v[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE_00000001, 34};
        v[2]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, 34};
        v[3]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 64'h40000000_00000000, 34};
        v[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFFD, 34};
        v[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFD, 34};
        v[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       64'h00000002_0000000E, 34};
        v[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        64'h00000002_0000000E, 34};
        v[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 64'h00000005_FFFFFFFF, 1};
        v[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        64'h00000005_FFFFFFFF, 1};
        v[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000, 1};
        v[11] = '{3'd5, 32'h00000009, 32'd0,        32'hFFFFFFFF, 64'h00000009_FFFFFFFF, 1};
        for (int i = 0; i < 12; i++) begin
            tick();
            run_op(v[i].op, v[i].a, v[i].b, lat, r, m);
            tests++; if (lat != v[i].lat) begin fails++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, v[i].lat); end
            tests++; if (r !== v[i].res) begin fails++; $display("FAIL vec%0d_result got %h want %h", i, r, v[i].res); end
            tests++; if (m !== v[i].mres) begin fails++; $display("FAIL vec%0d_mul_res got %h want %h", i, m, v[i].mres); end
        end
        tick();
    endtask

    task automatic test_flush();
        int pulses = 0;
        logic [31:0] prev_r;
        logic [63:0] prev_m;
        prev_r = result; prev_m = mul_res;
        op = 3'd4; data0 = 32'd1000; data1 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_pre_busy got %b want 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL flush_no_done got %0d pulses want 0", pulses); end
        tests++; if (result !== prev_r) begin fails++; $display("FAIL flush_result_held got %h want %h", result, prev_r); end
        tests++; if (mul_res !== prev_m) begin fails++; $display("FAIL flush_mul_res_held got %h want %h", mul_res, prev_m); end
        // flush and start together while idle: the start is dropped.
        op = 3'd0; data0 = 32'd3; data1 = 32'd3; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL flush_start_dropped got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] r;
        logic [63:0] m;
        tick();
        run_op(3'd5, 32'd100, 32'd7, lat, r, m);
        tests++; if (r !== 32'd14) begin fails++; $display("FAIL b2b_first_result got %h want e", r); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_in_done got %b want 0", busy); end
        // Still in the done cycle: the next request must be taken at this edge.
        run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, lat, r, m);
        tests++; if (lat != 34) begin fails++; $display("FAIL b2b_latency got %0d want 34", lat); end
        tests++; if (r !== 32'hFFFFFFEB) begin fails++; $display("FAIL b2b_second_result got %h want ffffffeb", r); end
        tick();
    endtask

    task automatic test_start_busy();
        int n;
        int lat = -1;
        int pulses = 0;
        tick();
        op = 3'd5; data0 = 32'd100; data1 = 32'd7; start = 1'b1;
        tick();
        n = 0;
        op = 3'd0; data0 = 32'd7; data1 = 32'hFFFFFFFD;
        for (int i = 0; i < 5; i++) begin
            tick();
            n++;
        end
        start = 1'b0; data0 = 32'h12345678; data1 = 32'h0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                lat = n + 1;
                break;
            end
            tick();
            n++;
        end
        tests++; if (lat != 34) begin fails++; $display("FAIL busy_start_latency got %0d want 34", lat); end
        tests++; if (result !== 32'd14) begin fails++; $display("FAIL busy_start_result got %h want e", result); end
        tick();
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL busy_start_not_queued got %0d pulses want 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        op = 3'd3; data0 = 32'hFFFFFFFF; data1 = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_busy got %b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %b want 0", done); end
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL rst_mid_result got %h want 0", result); end
        tests++; if (mul_res !== 64'h0) begin fails++; $display("FAIL rst_mid_mul_res got %h want 0", mul_res); end
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL rst_mid_no_done got %0d pulses want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_flush();
        test_back_to_back();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
